// File: rtl/fir_meter_pkg.sv
// Shared types and constants for the FIR response meter.
package fir_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meter_state_t;

  localparam int CNT_W_DEF     = 16;
  localparam int FRAC_BITS     = 30;
  localparam int INT_BITS      = 9;
  // Q9.30 plus sign bit gives the 40-bit filter output word.
  localparam int OUT_WIDTH_DEF = 1 + INT_BITS + FRAC_BITS;

endpackage

// File: rtl/fir_extrema_tracker.sv
// Signed running max/min registers with load (first sample), update and hold.
module fir_extrema_tracker
  import fir_meter_pkg::*;
#(
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        update,
  input  logic signed [OUT_WIDTH-1:0] y,
  output logic signed [OUT_WIDTH-1:0] max_y,
  output logic signed [OUT_WIDTH-1:0] min_y,
  output logic signed [OUT_WIDTH-1:0] max_nxt,
  output logic signed [OUT_WIDTH-1:0] min_nxt
);

  // Next values are exported so the amplitude can include the final sample.
  always_comb begin
    max_nxt = max_y;
    min_nxt = min_y;
    if (load) begin
      max_nxt = y;
      min_nxt = y;
    end else if (update) begin
      if (y > max_y) max_nxt = y;
      if (y < min_y) min_nxt = y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_y <= '0;
      min_y <= '0;
    end else begin
      max_y <= max_nxt;
      min_y <= min_nxt;
    end
  end

endmodule

// File: rtl/fir_response_meter.sv
// Settle/measure window over the FIR output stream, reporting signed extremes and amplitude.
// Define FIR_METER_P2P_EN to report half peak-to-peak instead of the peak as amp.
module fir_response_meter
  import fir_meter_pkg::*;
#(
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNT_W-1:0]            settle_cycles,
  input  logic [CNT_W-1:0]            window_cycles,
  input  logic                        y_valid,
  input  logic signed [OUT_WIDTH-1:0] y,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [OUT_WIDTH-1:0] max_y,
  output logic signed [OUT_WIDTH-1:0] min_y,
  output logic signed [OUT_WIDTH-1:0] amp
);

  meter_state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, r_settle, r_window;
  logic signed [OUT_WIDTH-1:0] r_amp;
  logic signed [OUT_WIDTH-1:0] w_max_nxt, w_min_nxt;
  logic                        w_load, w_update, w_cnt_en, w_meas_last;

  // Span is formed one bit wider so full-scale extremes cannot overflow.
  function automatic logic signed [OUT_WIDTH-1:0] amp_of(
    input logic signed [OUT_WIDTH-1:0] mx,
    input logic signed [OUT_WIDTH-1:0] mn
  );
`ifdef FIR_METER_P2P_EN
    logic signed [OUT_WIDTH:0] span;
    span   = (OUT_WIDTH+1)'(mx) - (OUT_WIDTH+1)'(mn);
    amp_of = OUT_WIDTH'(span >>> 1);
`else
    amp_of = mx;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_update    = 1'b0;
    w_cnt_en    = 1'b0;
    w_meas_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (settle_cycles == '0) ? MEASURE : SETTLE;
      end
      SETTLE: begin
        w_cnt_en = y_valid;
        if (y_valid && (r_cnt == r_settle - CNT_W'(1))) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        w_cnt_en = y_valid;
        if (y_valid) begin
          w_load   = (r_cnt == '0);
          w_update = (r_cnt != '0);
          if (r_cnt == r_window - CNT_W'(1)) begin
            w_meas_last = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_settle <= '0;
      r_window <= '0;
      r_amp    <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_settle <= settle_cycles;
        r_window <= (window_cycles == '0) ? CNT_W'(1) : window_cycles;
      end
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_cnt_en)          r_cnt <= r_cnt + CNT_W'(1);
      if (w_meas_last) r_amp <= amp_of(w_max_nxt, w_min_nxt);
    end
  end

  fir_extrema_tracker #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .update  (w_update),
    .y       (y),
    .max_y   (max_y),
    .min_y   (min_y),
    .max_nxt (w_max_nxt),
    .min_nxt (w_min_nxt)
  );

  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == DONE);
  assign amp       = r_amp;

endmodule

// File: tb/tb_fir_response_meter.sv
// Directed, table-driven bench for fir_response_meter (default or FIR_METER_P2P_EN build).
module tb_fir_response_meter;
  localparam int W  = 40;
  localparam int CW = 16;

  logic                clk = 1'b0;
  logic                rst, start, y_valid, res_ready;
  logic [CW-1:0]       settle_cycles, window_cycles;
  logic signed [W-1:0] y, max_y, min_y, amp;
  logic                busy, res_valid;

  always #5 clk = ~clk;

  fir_response_meter #(.OUT_WIDTH(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .settle_cycles (settle_cycles),
    .window_cycles (window_cycles),
    .y_valid       (y_valid),
    .y             (y),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .max_y         (max_y),
    .min_y         (min_y),
    .amp           (amp)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int     settle;
    int     window;
    int     first;
    int     count;
    bit     gap;
    longint emax;
    longint emin;
    longint eamp_pk;
    longint eamp_p2p;
  } vec_t;

  vec_t   vecs[6];
  longint pool[32];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint exp_amp(input vec_t v);
`ifdef FIR_METER_P2P_EN
    return v.eamp_p2p;
`else
    return v.eamp_pk;
`endif
  endfunction

  task automatic run_vec(input vec_t v, input int hold);
    longint ea;
    ea            = exp_amp(v);
    settle_cycles = CW'(v.settle);
    window_cycles = CW'(v.window);
    start         = 1'b1;
    step();
    start         = 1'b0;
    settle_cycles = '1;
    window_cycles = '1;
    for (int i = 0; i < v.count; i++) begin
      if (v.gap) begin
        y_valid = 1'b0;
        y       = 40'sd7777;
        step();
      end
      if (i == v.count - 1) begin
        chk("pre_done_res_valid", res_valid, 0);
        chk("pre_done_busy", busy, 1);
      end
      y_valid = 1'b1;
      y       = pool[v.first + i][W-1:0];
      step();
    end
    y_valid = 1'b0;
    y       = '0;
    chk("done_res_valid", res_valid, 1);
    chk("done_busy", busy, 1);
    chk("max_y", max_y, v.emax);
    chk("min_y", min_y, v.emin);
    chk("amp", amp, ea);
    for (int c = 0; c < hold; c++) begin
      start   = 1'b1;
      y_valid = 1'b1;
      y       = -40'sd999999;
      step();
      chk("hold_res_valid", res_valid, 1);
      chk("hold_max_y", max_y, v.emax);
      chk("hold_min_y", min_y, v.emin);
      chk("hold_amp", amp, ea);
    end
    y_valid   = 1'b0;
    start     = 1'b1;
    res_ready = 1'b1;
    step();
    chk("ack_res_valid", res_valid, 0);
    chk("ack_busy", busy, 0);
    start     = 1'b0;
    res_ready = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("kept_max_y", max_y, v.emax);
    chk("kept_amp", amp, ea);
  endtask

  initial begin
    longint big;
    big = longint'(1) << 39;
    pool[0] = 1000; pool[1] = 1000; pool[2] = 1000; pool[3] = 1000;
    pool[4] = 100;  pool[5] = -3;   pool[6] = 7;    pool[7] = 9;    pool[8] = 2;
    pool[9] = -20;
    pool[10] = 5;   pool[11] = -8;  pool[12] = 3;
    pool[13] = big - 1; pool[14] = -big;
    pool[15] = -500; pool[16] = 500; pool[17] = 10; pool[18] = 10;
    pool[19] = -1;   pool[20] = -1;
    pool[21] = 50;   pool[22] = -7;  pool[23] = -3; pool[24] = -9;
    //         settle win first cnt gap  max      min   amp_pk   amp_p2p
    vecs[0] = '{4, 5, 0,  9, 1'b0, 100,     -3,   100,     51};
    vecs[1] = '{0, 0, 9,  1, 1'b0, -20,     -20,  -20,     0};
    vecs[2] = '{0, 3, 10, 3, 1'b1, 5,       -8,   5,       6};
    vecs[3] = '{0, 2, 13, 2, 1'b0, big - 1, -big, big - 1, big - 1};
    vecs[4] = '{2, 4, 15, 6, 1'b0, 10,      -1,   10,      5};
    vecs[5] = '{1, 3, 21, 4, 1'b0, -3,      -9,   -3,      3};

    rst = 1'b1; start = 1'b1; y_valid = 1'b1; y = 40'sd55; res_ready = 1'b1;
    settle_cycles = 16'd2; window_cycles = 16'd2;
    step(); step();
    start = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_max_y", max_y, 0);
    chk("rst_min_y", min_y, 0);
    chk("rst_amp", amp, 0);
    rst = 1'b0; y_valid = 1'b0; res_ready = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], (k == 2) ? 10 : 0);

    // Reset in the middle of a measurement window.
    settle_cycles = 16'd0; window_cycles = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    y_valid = 1'b1; y = 40'sd123456;
    step();
    y = 40'sd654321;
    step();
    chk("mid_busy", busy, 1);
    rst = 1'b1; y_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_max_y", max_y, 0);
    chk("mid_rst_min_y", min_y, 0);
    y_valid = 1'b1; y = 40'sd4242;
    for (int c = 0; c < 5; c++) step();
    y_valid = 1'b0;
    chk("after_rst_res_valid", res_valid, 0);
    chk("after_rst_busy", busy, 0);
    run_vec(vecs[0], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
